// File: rtl/arb4_grant_ctrl.sv
// Four-requester arbiter with a registered one-hot grant, an encoded index and a hold limit.
// Define ARB4_ROUND_ROBIN_EN to rotate priority away from the most recent owner.
module arb4_grant_ctrl #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  logic [0:0] state_q,    state_d;
  logic [3:0] gnt_q,      gnt_d;
  logic [1:0] gntId_q,    gntId_d;
  logic       gntValid_q, gntValid_d;
  logic       preempt_q,  preempt_d;
  logic [7:0] holdCnt_q,  holdCnt_d;
  logic [1:0] lastId_q,   lastId_d;

  logic [1:0] winId;
  logic [1:0] cand;
  logic       winFound;

  // Later loop iterations override earlier ones, so the final candidate has top priority.
  always_comb begin
    winId    = 2'd0;
    winFound = 1'b0;
    cand     = 2'd0;
    for (int k = 4; k >= 1; k--) begin
`ifdef ARB4_ROUND_ROBIN_EN
      cand = lastId_q - 2'(k);
`else
      cand = 2'(4 - k);
`endif
      if (req[cand]) begin
        winId    = cand;
        winFound = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gntId_d    = gntId_q;
    gntValid_d = gntValid_q;
    preempt_d  = 1'b0;
    holdCnt_d  = holdCnt_q;
    lastId_d   = lastId_q;
    case (state_q)
      ST_IDLE: begin
        if (winFound) begin
          state_d    = ST_BUSY;
          gnt_d      = 4'b0001 << winId;
          gntId_d    = winId;
          gntValid_d = 1'b1;
          holdCnt_d  = 8'd1;
          lastId_d   = winId;
        end
      end
      default: begin
        // Release priority: done, then withdrawal, then the forced hold-limit release.
        if (done || !req[gntId_q] || (holdCnt_q == HOLD_LIMIT)) begin
          state_d    = ST_IDLE;
          gnt_d      = 4'b0000;
          gntId_d    = 2'd0;
          gntValid_d = 1'b0;
          preempt_d  = !done && req[gntId_q];
        end else begin
          holdCnt_d = holdCnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 4'b0000;
      gntId_q    <= 2'd0;
      gntValid_q <= 1'b0;
      preempt_q  <= 1'b0;
      holdCnt_q  <= 8'd0;
      lastId_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gntId_q    <= gntId_d;
      gntValid_q <= gntValid_d;
      preempt_q  <= preempt_d;
      holdCnt_q  <= holdCnt_d;
      lastId_q   <= lastId_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gntId_q;
  assign gnt_valid = gntValid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_arb4_grant_ctrl.sv
// Bench for arb4_grant_ctrl: directed scenarios plus randomized traffic against a reference model.
// Honours ARB4_ROUND_ROBIN_EN the same way the design does.
module tb_arb4_grant_ctrl;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: owner index (-1 when idle), cycles held so far, last owner, preempt flag.
  int mOwner = -1;
  int mHold  = 0;
  int mLast  = 0;
  bit mPre   = 1'b0;

  arb4_grant_ctrl #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  function automatic int pickWinner(input logic [3:0] r, input int last);
`ifdef ARB4_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last - k + 8) % 4;
      if (r[c]) return c;
    end
`else
    for (int c = 3; c >= 0; c--) begin
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic modelStep(input logic [3:0] r, input logic d, input logic rn);
    if (!rn) begin
      mOwner = -1; mHold = 0; mLast = 0; mPre = 1'b0;
    end else if (mOwner < 0) begin
      mPre = 1'b0;
      if (r != 4'b0000) begin
        mOwner = pickWinner(r, mLast);
        mHold  = 1;
        mLast  = mOwner;
      end
    end else begin
      mPre = 1'b0;
      if (d || !r[mOwner]) begin
        mOwner = -1;
      end else if (mHold == MAXH) begin
        mOwner = -1;
        mPre   = 1'b1;
      end else begin
        mHold++;
      end
    end
  endtask

  // Drive inputs at the falling edge, advance the model at the rising edge, settle before checks.
  task automatic applyStimulus(input logic [3:0] r, input logic d, input logic rn);
    @(negedge clk);
    req = r; done = d; rst_n = rn;
    @(posedge clk);
    modelStep(r, d, rn);
    #1;
  endtask

  task automatic test_reset;
    applyStimulus(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    assertCount++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== 8'b0000_00_0_0) begin
      failCount++;
      $display("[TB] FAIL reset_state: got gnt=%b id=%0d v=%b p=%b, want 0000/0/0/0", gnt, gnt_id, gnt_valid, preempt);
    end
    applyStimulus(4'b1111, 1'b0, 1'b1);
    assertCount++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== 8'b1000_11_1_0) begin
      failCount++;
      $display("[TB] FAIL reset_first_grant: got gnt=%b id=%0d v=%b p=%b, want 1000/3/1/0", gnt, gnt_id, gnt_valid, preempt);
    end
  endtask

  task automatic test_priority_withdrawal;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0101, 1'b0, 1'b1);
    assertCount++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== 8'b0100_10_1_0) begin
      failCount++;
      $display("[TB] FAIL prio_grant: got gnt=%b id=%0d v=%b p=%b, want 0100/2/1/0", gnt, gnt_id, gnt_valid, preempt);
    end
    applyStimulus(4'b0001, 1'b0, 1'b1);
    assertCount++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== 8'b0000_00_0_0) begin
      failCount++;
      $display("[TB] FAIL withdraw_idle: got gnt=%b id=%0d v=%b p=%b, want 0000/0/0/0", gnt, gnt_id, gnt_valid, preempt);
    end
    applyStimulus(4'b0001, 1'b0, 1'b1);
    assertCount++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== 8'b0001_00_1_0) begin
      failCount++;
      $display("[TB] FAIL withdraw_regrant: got gnt=%b id=%0d v=%b p=%b, want 0001/0/1/0", gnt, gnt_id, gnt_valid, preempt);
    end
  endtask

  task automatic test_back_to_back;
    int expIds [5];
`ifdef ARB4_ROUND_ROBIN_EN
    expIds = '{3, 2, 1, 0, 3};
`else
    expIds = '{3, 3, 3, 3, 3};
`endif
    applyStimulus(4'b0000, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      logic [3:0] expGnt;
      expGnt = 4'b0001 << expIds[g];
      applyStimulus(4'b1111, 1'b0, 1'b1);
      applyStimulus(4'b1111, 1'b0, 1'b1);
      assertCount++;
      if ({gnt, gnt_id, gnt_valid} !== {expGnt, 2'(expIds[g]), 1'b1}) begin
        failCount++;
        $display("[TB] FAIL b2b_grant%0d: got gnt=%b id=%0d v=%b, want %b/%0d/1", g, gnt, gnt_id, gnt_valid, expGnt, expIds[g]);
      end
      applyStimulus(4'b1111, 1'b1, 1'b1);
      assertCount++;
      if ({gnt, gnt_valid, preempt} !== 6'b0000_0_0) begin
        failCount++;
        $display("[TB] FAIL b2b_idle%0d: got gnt=%b v=%b p=%b, want 0000/0/0", g, gnt, gnt_valid, preempt);
      end
    end
  endtask

  task automatic test_hold_limit;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    for (int c = 1; c <= MAXH; c++) begin
      applyStimulus(4'b0010, 1'b0, 1'b1);
      assertCount++;
      if ({gnt, gnt_id, gnt_valid, preempt} !== 8'b0010_01_1_0) begin
        failCount++;
        $display("[TB] FAIL hold_cycle%0d: got gnt=%b id=%0d v=%b p=%b, want 0010/1/1/0", c, gnt, gnt_id, gnt_valid, preempt);
      end
    end
    applyStimulus(4'b0010, 1'b0, 1'b1);
    assertCount++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== 8'b0000_00_0_1) begin
      failCount++;
      $display("[TB] FAIL hold_preempt: got gnt=%b id=%0d v=%b p=%b, want 0000/0/0/1", gnt, gnt_id, gnt_valid, preempt);
    end
    applyStimulus(4'b0010, 1'b0, 1'b1);
    assertCount++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== 8'b0010_01_1_0) begin
      failCount++;
      $display("[TB] FAIL hold_regrant: got gnt=%b id=%0d v=%b p=%b, want 0010/1/1/0", gnt, gnt_id, gnt_valid, preempt);
    end
  endtask

  task automatic test_done_precedence;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    for (int c = 1; c <= MAXH; c++) applyStimulus(4'b0010, 1'b0, 1'b1);
    applyStimulus(4'b0010, 1'b1, 1'b1);
    assertCount++;
    if ({gnt, gnt_valid, preempt} !== 6'b0000_0_0) begin
      failCount++;
      $display("[TB] FAIL done_over_limit: got gnt=%b v=%b p=%b, want 0000/0/0", gnt, gnt_valid, preempt);
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0000, 1'b1, 1'b1);
      assertCount++;
      if ({gnt, gnt_id, gnt_valid, preempt} !== 8'b0000_00_0_0) begin
        failCount++;
        $display("[TB] FAIL done_idle%0d: got gnt=%b id=%0d v=%b p=%b, want 0000/0/0/0", c, gnt, gnt_id, gnt_valid, preempt);
      end
    end
  endtask

  task automatic test_reset_mid_grant;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b1);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    assertCount++;
    if ({gnt, gnt_id, gnt_valid, preempt} !== 8'b0000_00_0_0) begin
      failCount++;
      $display("[TB] FAIL midreset_clear: got gnt=%b id=%0d v=%b p=%b, want 0000/0/0/0", gnt, gnt_id, gnt_valid, preempt);
    end
    applyStimulus(4'b1111, 1'b0, 1'b1);
    assertCount++;
    if ({gnt, gnt_id, gnt_valid} !== 7'b1000_11_1) begin
      failCount++;
      $display("[TB] FAIL midreset_regrant: got gnt=%b id=%0d v=%b, want 1000/3/1", gnt, gnt_id, gnt_valid);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      logic [3:0] r;
      logic       d;
      logic       rn;
      logic [3:0] expGnt;
      logic [1:0] expId;
      r  = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 5) == 0);
      rn = ($urandom_range(0, 60) != 0);
      if ($urandom_range(0, 3) != 0 && mOwner >= 0) r[mOwner] = 1'b1;
      applyStimulus(r, d, rn);
      expGnt = (mOwner < 0) ? 4'b0000 : (4'b0001 << mOwner);
      expId  = (mOwner < 0) ? 2'd0 : 2'(mOwner);
      assertCount++;
      if ({gnt, gnt_id, gnt_valid, preempt} !== {expGnt, expId, (mOwner >= 0), mPre}) begin
        failCount++;
        $display("[TB] FAIL random%0d: got gnt=%b id=%0d v=%b p=%b, want %b/%0d/%b/%b",
                 n, gnt, gnt_id, gnt_valid, preempt, expGnt, expId, (mOwner >= 0), mPre);
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority_withdrawal();
    test_back_to_back();
    test_hold_limit();
    test_done_precedence();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/arb4_grant_ctrl.md
# arb4_grant_ctrl

- Sequential 4-requester arbiter for a single shared downstream resource.
- Samples a 4-bit request vector and issues one registered one-hot grant plus a 2-bit encoded grant index (same encoding as the team's 4-to-2 priority encoder: index 3 = req[3]).
- Holds the grant until the owner signals completion, withdraws its request, or exceeds a hold limit.
- Sits between requester agents and the shared datapath.

## Interface

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  4  request vector; req[i] high = requester i wants the resource.
- done  input  1  current owner releases the resource; ignored when no grant is active.
- gnt  output  4  registered one-hot grant; 0000 when idle.
- gnt_id  output  2  encoded index of the granted requester; 0 when idle.
- gnt_valid  output  1  high while any grant is active (equals |gnt).
- preempt  output  1  one-cycle pulse: grant was force-released by the hold limit.

## Operation

- States: IDLE (no grant) and BUSY (one grant active). Internal registers: hold_cnt (8-bit), last_id (2-bit).
- Reset (rst_n low at an edge, regardless of state):
  - state IDLE; gnt = 0000, gnt_id = 0, gnt_valid = 0, preempt = 0.
  - hold_cnt = 0, last_id = 0.
- IDLE:
  - If req == 0000: remain in IDLE.
  - Otherwise select a winner by the priority order below, load gnt/gnt_id, set gnt_valid = 1, set hold_cnt = 1, set last_id = winner, go to BUSY.
- Fixed priority order: 3 > 2 > 1 > 0.
- BUSY release conditions, evaluated each edge in priority order:
  - done = 1: release, preempt = 0.
  - req[gnt_id] = 0 (withdrawal): release, preempt = 0.
  - hold_cnt == MAX_HOLD: release, preempt = 1.
  - Otherwise: hold_cnt increments; gnt is unchanged.
- On release: gnt = 0000, gnt_id = 0, gnt_valid = 0; go to IDLE. last_id is retained.
- preempt is high only on the cycle immediately after a forced release and clears on the next edge.
- Request changes by non-owners while in BUSY have no effect until re-arbitration.
- The grant never changes owner directly; every change of owner passes through IDLE.

## Timing

- Request-to-grant latency: a request sampled in IDLE at edge k gives gnt valid from edge k through the next edge.
- Release latency: a release condition sampled at edge k clears gnt after edge k.
- Each release forces exactly one IDLE cycle; re-arbitration happens at the following edge.
- Minimum spacing between grants: one cycle with gnt_valid = 0.
- With continuous req and no done, gnt_valid stays high for exactly MAX_HOLD cycles.
- MAX_HOLD = 1: each grant lasts one cycle, then 1 idle cycle with preempt = 1 (unless done or a withdrawal applies).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- Macro: ARB4_ROUND_ROBIN_EN.
- Defined:
  - The most recently granted index becomes lowest priority.
  - Search runs downward from last_id−1 with wrap, e.g. last_id = 3 gives order 2,1,0,3; last_id = 1 gives order 0,3,2,1.
  - After reset (last_id = 0) the order is 3,2,1,0, identical to fixed priority.
- Undefined:
  - Fixed priority 3 > 2 > 1 > 0 always.
  - last_id is still tracked but does not affect selection.

## Test plan

- Reset: rst_n = 0 for 2 edges with req = 1111, done = 0 -> gnt = 0000, gnt_id = 0, gnt_valid = 0, preempt = 0. First edge after rst_n = 1 -> gnt = 1000, gnt_id = 3.
- Fixed priority with withdrawal (macro undefined): req = 0101 -> gnt = 0100, gnt_id = 2. Drop req to 0001 -> gnt = 0000 for 1 cycle, then gnt = 0001, gnt_id = 0, preempt = 0 throughout.
- Round robin (macro defined): req = 1111 held; owner pulses done on its 2nd grant cycle -> grant sequence 3,2,1,0,3, each grant 2 cycles followed by 1 idle cycle.
- Hold limit (MAX_HOLD = 4): req = 0010 held, done = 0 -> gnt = 0010 for exactly 4 cycles, then 1 cycle of gnt = 0000 with preempt = 1, then gnt = 0010 again with preempt = 0.
- Done precedence: MAX_HOLD = 4 and done = 1 on the 4th grant cycle -> release with preempt = 0. done = 1 while IDLE with req = 0000 -> no output change.
- Reset mid-grant: rst_n low during BUSY with round robin enabled, last_id = 3 -> all outputs 0 after the edge. After release with req = 1111 -> gnt = 1000 (last_id reset to 0).
